// File: rtl/stage_counter.sv
// Pipeline-stage sequencer for the multi-cycle control unit.
// Ports: clk, reset (async, active-high), out = registered stage number.
module stage_counter #(
    parameter int WIDTH = 3,
    parameter int FIRST = 1,
    parameter int LAST  = 5
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] FIRST_V = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0] LAST_V  = WIDTH'(LAST);
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

    generate
        if (FIRST == 0) begin : g_bad_first
            $error("stage_counter: FIRST must be nonzero");
        end
        if (FIRST > LAST) begin : g_bad_order
            $error("stage_counter: FIRST must not exceed LAST");
        end
        if (LAST >= (2 ** WIDTH)) begin : g_bad_width
            $error("stage_counter: LAST does not fit in WIDTH bits");
        end
    endgenerate

    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_d;
    logic             in_run;

    // Only FIRST..LAST-1 advance; idle, LAST and any illegal
    // encoding all land on FIRST, so no modulo wrap is needed.
    always_comb begin
        in_run  = (stage_q >= FIRST_V) && (stage_q < LAST_V);
        stage_d = FIRST_V;
        if (in_run) begin
            stage_d = stage_q + ONE_V;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out = stage_q;

endmodule

// File: tb/tb_stage_counter.sv
// Directed bench for stage_counter: default and wide/offset instances.
// Outputs are sampled on the falling clock edge.
module tb_stage_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] out;
    logic [3:0] out2;

    int n_checks = 0;
    int n_errors = 0;

    int seq5 [12] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
    int seq8 [12] = '{2, 3, 4, 5, 6, 7, 8, 9, 2, 3, 4, 5};

    stage_counter dut (
        .clk   (clk),
        .reset (reset),
        .out   (out)
    );

    stage_counter #(
        .WIDTH (4),
        .FIRST (2),
        .LAST  (9)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .out   (out2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst_async", int'(out), 0);
        check("rst_async2", int'(out2), 0);

        repeat (3) begin
            @(negedge clk);
            check("rst_hold", int'(out), 0);
        end
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("seq5[%0d]", i), int'(out), seq5[i]);
            check($sformatf("seq8[%0d]", i), int'(out2), seq8[i]);
        end

        @(negedge clk);
        check("pre_mid", int'(out), 3);
        #2 reset = 1'b1;
        #1;
        check("mid_rst", int'(out), 0);
        check("mid_rst2", int'(out2), 0);

        repeat (4) begin
            @(negedge clk);
            check("hold4", int'(out), 0);
            check("hold4_2", int'(out2), 0);
        end
        reset = 1'b0;

        @(negedge clk);
        check("rel_1", int'(out), 1);
        check("rel2_2", int'(out2), 2);
        @(negedge clk);
        check("rel_2", int'(out), 2);
        check("rel2_3", int'(out2), 3);

        force dut.stage_q = 3'd7;
        #1 release dut.stage_q;
        @(negedge clk);
        check("ill7_1", int'(out), 1);
        @(negedge clk);
        check("ill7_2", int'(out), 2);

        force dut.stage_q = 3'd6;
        #1 release dut.stage_q;
        @(negedge clk);
        check("ill6_1", int'(out), 1);
        @(negedge clk);
        check("ill6_2", int'(out), 2);

        force dut2.stage_q = 4'd15;
        #1 release dut2.stage_q;
        @(negedge clk);
        check("ill15_w", int'(out2), 2);

        force dut2.stage_q = 4'd1;
        #1 release dut2.stage_q;
        @(negedge clk);
        check("ill1_w", int'(out2), 2);
        @(negedge clk);
        check("ill1_w3", int'(out2), 3);

        force dut2.stage_q = 4'd9;
        #1 release dut2.stage_q;
        @(negedge clk);
        check("wrap9_w", int'(out2), 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
